processor_run_controller: RTL and testbench
===========================================

// Module: processor_run_controller
// PURPOSE
//   Host-side initiator for the multicore processor's start/done handshake.
//   On a run request it waits for processor_ready, drives an active-low startN
//   pulse, then waits for processDone. It reports the run's cycle count, a done
//   pulse and a timeout flag. Sits between the board/UART control logic and the
//   processor top.
// PARAMETERS
//   CNT_W           32         width of cycle_count and of the timeout timer
//   TIMEOUT_CYCLES  1_000_000  max cycles from accept to completion; 0 = timeout disabled
//   START_PULSE_LEN 1          cycles startN is held low (>=1)
//   RUN_CNT_W       16         width of run_count
// PORTS
//   clk             in   1          clock, all logic on posedge
//   rst             in   1          synchronous reset, active-high
//   run_req         in   1          level request, sampled only in IDLE
//   processor_ready in   1          processor idle and able to accept start
//   processDone     in   1          processor finished (level, may stay high)
//   startN          out  1          start strobe to processor, active-low
//   busy            out  1          high in every state except IDLE
//   done            out  1          one-cycle pulse when a run ends (normal or timeout)
//   timeout         out  1          last run ended by timeout; cleared when the next run is accepted
//   cycle_count     out  CNT_W      cycles of the last/current run, saturating
//   run_count       out  RUN_CNT_W  completed runs incl. timeouts, wraps modulo 2^RUN_CNT_W
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge):
//   - state=IDLE, startN=1, busy=0, done=0, timeout=0, cycle_count=0, run_count=0.
//   - Reset overrides everything, including mid-run. startN is high the cycle after the reset edge.
//   FSM states: IDLE, WAIT_READY, START, RUN, DONE (registered; all outputs registered).
//   - IDLE: if run_req=1 -> WAIT_READY.
//     - Clear the timer and timeout; cycle_count holds its last value.
//   - WAIT_READY: if processor_ready=1 && processDone=0 -> START.
//     - On entry to START: cycle_count<=0 and startN<=0.
//   - START: startN=0 for exactly START_PULSE_LEN cycles (pulse counter), then -> RUN.
//     - startN returns to 1 on the edge entering RUN.
//   - RUN: if processDone=1 -> DONE.
//   - DONE: done=1 for this single cycle, run_count+1 -> IDLE.
//   cycle_count:
//   - +1 on every edge taken while in START or RUN, including the edge leaving RUN.
//   - Saturates at 2^CNT_W-1 and holds in DONE/IDLE.
//   Timeout:
//   - The timer counts every cycle in WAIT_READY, START and RUN.
//   - If TIMEOUT_CYCLES!=0 and the timer reaches TIMEOUT_CYCLES, take the next edge -> DONE with
//     timeout<=1 and startN<=1 (this can abort START).
//   - If processDone=1 and timeout expire on the same edge in RUN, processDone wins (timeout=0).
//   Requests:
//   - run_req while busy is ignored, not queued.
//   - run_req held high gives back-to-back runs, with exactly one IDLE cycle between done and the
//     next WAIT_READY.
//   - A stuck-high processDone blocks WAIT_READY and therefore ends in timeout (no spurious start).
//   Handshake: startN never goes low unless processor_ready was 1 on the preceding edge.
// STRUCTURE
//   - Include file proc_ctrl_defs.vh: state encodings (3-bit localparams) and shared defaults
//     (CNT_W, TIMEOUT_CYCLES). Other host-side control blocks reuse it.
//   - One sub-module, sat_counter #(W): synchronous clear, enable, saturate at all-ones.
//     Instantiated for cycle_count and for the timeout timer.
//   - The START pulse counter and run_count stay inline.
// TESTING
//   1 Reset mid-RUN: rst=1 for 1 cycle while startN=0/busy=1
//       -> next cycle state IDLE, startN=1, busy=0, all counts 0.
//   2 Nominal run: ready=1, run_req pulse, processDone rises 5 cycles after startN falls
//       -> startN low 1 cycle, done pulse, cycle_count=6, run_count=1, timeout=0.
//   3 Ready late: processor_ready held 0 for 10 cycles after run_req
//       -> startN stays 1 throughout, falls on the edge after ready=1.
//   4 Timeout: TIMEOUT_CYCLES=20, processDone never rises
//       -> done after 20 busy cycles, timeout=1, startN=1, run_count=1.
//       Next run_req clears timeout.
//   5 Tie: TIMEOUT_CYCLES=8, processDone rises on the same edge the timer hits 8
//       -> done=1, timeout=0.
//   6 Back-to-back: run_req held high, processDone dropped between runs
//       -> 3 runs, one IDLE cycle between each done and the next WAIT_READY.
//       run_req pulses while busy ignored; run_count=3; START_PULSE_LEN=3 gives 3-cycle startN lows.

Source files
------------

// File: rtl/processor_run_controller_pkg.sv
// Types for the processor run controller, built on the shared host-control encodings.
package processor_run_controller_pkg;
  `include "proc_ctrl_defs.vh"

  typedef enum logic [2:0] {
    S_IDLE       = PC_ST_IDLE,
    S_WAIT_READY = PC_ST_WAIT_READY,
    S_START      = PC_ST_START,
    S_RUN        = PC_ST_RUN,
    S_DONE       = PC_ST_DONE
  } state_t;
endpackage

// File: rtl/proc_ctrl_defs.vh
// Shared host-side control definitions: run-controller state encodings and counter defaults.
// Include inside a package or module scope; it declares only localparams.
localparam logic [2:0] PC_ST_IDLE       = 3'd0;
localparam logic [2:0] PC_ST_WAIT_READY = 3'd1;
localparam logic [2:0] PC_ST_START      = 3'd2;
localparam logic [2:0] PC_ST_RUN        = 3'd3;
localparam logic [2:0] PC_ST_DONE       = 3'd4;

localparam int PC_DEF_CNT_W          = 32;
localparam int PC_DEF_TIMEOUT_CYCLES = 1_000_000;

// File: rtl/processor_run_controller_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (en && (q != '1)) q <= q + W'(1);
  end
endmodule

// File: rtl/processor_run_controller.sv
// Host-side start/done initiator for the processor: waits for ready, pulses startN low,
// waits for processDone, and reports cycle count, done pulse, timeout and run count.
module processor_run_controller
  import processor_run_controller_pkg::*;
#(
  parameter int CNT_W           = PC_DEF_CNT_W,
  parameter int TIMEOUT_CYCLES  = PC_DEF_TIMEOUT_CYCLES,
  parameter int START_PULSE_LEN = 1,
  parameter int RUN_CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_req,
  input  logic                 processor_ready,
  input  logic                 processDone,
  output logic                 startN,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [RUN_CNT_W-1:0] run_count
);
  localparam int              PW         = (START_PULSE_LEN > 1) ? $clog2(START_PULSE_LEN) : 1;
  localparam logic [PW-1:0]   PULSE_LAST = PW'(START_PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [PW-1:0]    r_pulse;
  logic [CNT_W-1:0] w_timer;
  logic             w_timing;
  logic             w_expire;
  logic             w_tmo;
  logic             w_start_entry;
  logic             w_cc_en;

  // Timer value TMO_LAST means this edge is the one on which it reaches TIMEOUT_CYCLES.
  always_comb begin
    w_timing      = (r_state == S_WAIT_READY) || (r_state == S_START) || (r_state == S_RUN);
    w_expire      = (TIMEOUT_CYCLES != 0) && w_timing && (w_timer == TMO_LAST);
    w_cc_en       = (r_state == S_START) || (r_state == S_RUN);
    w_next        = r_state;
    w_tmo         = 1'b0;
    case (r_state)
      S_IDLE:       if (run_req) w_next = S_WAIT_READY;
      S_WAIT_READY: begin
        if (w_expire) begin
          w_next = S_DONE;
          w_tmo  = 1'b1;
        end else if (processor_ready && !processDone) begin
          w_next = S_START;
        end
      end
      S_START: begin
        if (w_expire) begin
          w_next = S_DONE;
          w_tmo  = 1'b1;
        end else if (r_pulse == PULSE_LAST) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (processDone) begin
          w_next = S_DONE;
        end else if (w_expire) begin
          w_next = S_DONE;
          w_tmo  = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_start_entry = (r_state == S_WAIT_READY) && (w_next == S_START);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pulse   <= '0;
      startN    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      run_count <= '0;
    end else begin
      r_state <= w_next;
      r_pulse <= (r_state == S_START) ? r_pulse + PW'(1) : '0;
      startN  <= (w_next != S_START);
      busy    <= (w_next != S_IDLE);
      done    <= (w_next == S_DONE);
      if ((r_state == S_IDLE) && run_req) timeout <= 1'b0;
      else if (w_tmo)                     timeout <= 1'b1;
      if (w_next == S_DONE) run_count <= run_count + RUN_CNT_W'(1);
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle (
    .clk (clk),
    .rst (rst),
    .clr (w_start_entry),
    .en  (w_cc_en),
    .q   (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (r_state == S_IDLE),
    .en  (w_timing),
    .q   (w_timer)
  );
endmodule

// File: tb/tb_processor_run_controller.sv
// Directed bench for processor_run_controller; expected run results are queued at request time
// and checked by a monitor whenever done pulses.
module tb_processor_run_controller;
  localparam int CNT_W = 32;
  localparam int RCW   = 16;
  localparam int TMO   = 20;
  localparam int PLEN  = 3;

  logic             clk = 1'b0;
  logic             rst, run_req, processor_ready, processDone;
  logic             startN, busy, done, timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [RCW-1:0]   run_count;

  always #5 clk = ~clk;

  processor_run_controller #(
    .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO), .START_PULSE_LEN(PLEN), .RUN_CNT_W(RCW)
  ) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .processor_ready(processor_ready),
    .processDone(processDone), .startN(startN), .busy(busy), .done(done),
    .timeout(timeout), .cycle_count(cycle_count), .run_count(run_count)
  );

  typedef struct {
    logic        to;
    logic [31:0] cc;
    logic [15:0] rc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic to, input int cc, input int rc);
    exp_t e;
    e.to = to;
    e.cc = 32'(cc);
    e.rc = 16'(rc);
    q.push_back(e);
  endtask

  task automatic wait_low(input string nm);
    int n = 0;
    while (startN !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    chk(nm, startN, 0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  // Scoreboard plus startN pulse-width and ready-handshake checks, sampled on negedge.
  task automatic monitor();
    int   len = 0;
    logic rdy_last = 1'b0;
    logic sn_last = 1'b1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q.size() == 0) chk("sb_queue_nonempty", 64'(q.size()), 1);
        else begin
          e = q.pop_front();
          chk("sb_timeout", timeout, e.to);
          chk("sb_cycle_count", cycle_count, e.cc);
          chk("sb_run_count", run_count, e.rc);
          chk("sb_busy_in_done", busy, 1);
          chk("sb_startN_in_done", startN, 1);
        end
      end
      if (rst) len = 0;
      else if (startN === 1'b0) len++;
      else if (len != 0) begin
        chk("startN_low_len", 64'(len), PLEN);
        len = 0;
      end
      if (sn_last === 1'b1 && startN === 1'b0) chk("handshake_ready", rdy_last, 1);
      sn_last  = startN;
      rdy_last = processor_ready;
    end
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none

    rst = 1'b1; run_req = 1'b0; processor_ready = 1'b0; processDone = 1'b0;
    tick(); tick();
    chk("rst_startN", startN, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_run_count", run_count, 0);
    rst = 1'b0;
    tick();

    // reset while startN is low
    processor_ready = 1'b1;
    run_req = 1'b1; tick(); run_req = 1'b0;
    wait_low("t1_start");
    tick();
    chk("t1_pre_startN", startN, 0);
    chk("t1_pre_busy", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t1_startN", startN, 1);
    chk("t1_busy", busy, 0);
    chk("t1_cycle_count", cycle_count, 0);
    chk("t1_run_count", run_count, 0);
    chk("t1_timeout", timeout, 0);
    tick();
    chk("t1_stay_idle", busy, 0);

    // nominal: processDone rises 5 cycles after startN falls
    push(1'b0, 6, 1);
    run_req = 1'b1; tick(); run_req = 1'b0;
    wait_low("t2_start");
    repeat (5) tick();
    processDone = 1'b1;
    wait_done(n);
    chk("t2_done_latency", 64'(n), 1);
    processDone = 1'b0;
    tick(); tick();

    // processor_ready late by 10 cycles
    processor_ready = 1'b0;
    push(1'b0, 6, 2);
    run_req = 1'b1; tick(); run_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_startN_held", startN, 1);
    end
    processor_ready = 1'b1;
    tick();
    chk("t3_startN_fall", startN, 0);
    repeat (5) tick();
    processDone = 1'b1;
    wait_done(n);
    processDone = 1'b0;
    tick(); tick();

    // timeout in RUN: 20 busy cycles, then done
    push(1'b1, 19, 3);
    run_req = 1'b1; tick(); run_req = 1'b0;
    wait_done(n);
    chk("t4_busy_cycles", 64'(n), 20);
    chk("t4_startN", startN, 1);
    chk("t4_timeout", timeout, 1);
    tick(); tick();
    chk("t4_timeout_held", timeout, 1);

    // tie: processDone sampled on the edge the timer reaches 20
    push(1'b0, 19, 4);
    run_req = 1'b1; tick(); run_req = 1'b0;
    chk("t5_timeout_cleared", timeout, 0);
    wait_low("t5_start");
    repeat (18) tick();
    processDone = 1'b1;
    wait_done(n);
    chk("t5_done_latency", 64'(n), 1);
    processDone = 1'b0;
    tick(); tick();

    // stuck-high processDone never starts, ends in timeout, cycle_count held
    processDone = 1'b1;
    push(1'b1, 19, 5);
    run_req = 1'b1; tick(); run_req = 1'b0;
    wait_done(n);
    chk("t7_busy_cycles", 64'(n), 20);
    processDone = 1'b0;
    tick(); tick();

    // back-to-back runs with run_req held high
    run_req = 1'b1;
    for (int r = 0; r < 3; r++) begin
      push(1'b0, 6, 6 + r);
      wait_low("t6_start");
      repeat (5) tick();
      processDone = 1'b1;
      wait_done(n);
      chk("t6_done_latency", 64'(n), 1);
      processDone = 1'b0;
      if (r == 2) run_req = 1'b0;
      tick();
      chk("t6_idle_gap", busy, 0);
      tick();
      chk("t6_rearm", busy, (r < 2) ? 1 : 0);
    end
    chk("t6_run_count", run_count, 8);

    repeat (3) tick();
    chk("sb_drained", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
